// File: rtl/multi_channel_window_watchdog_if.sv
// ---------------------------------------------------------------------------
// multi_channel_window_watchdog_if
//
// Configuration bus of the multi-channel window watchdog. One channel is
// written per cycle while cfg_wr_en is high.
//
// Signals:
//   cfg_wr_en        write strobe
//   cfg_channel      target channel index
//   cfg_timeout      timeout T (0 selects the default timeout)
//   cfg_window_open  earliest legal kick count W (window mode only)
//   cfg_enable       channel enable
//
// Modports:
//   master  drives the bus (software / testbench side)
//   slave   receives the bus (watchdog side)
// ---------------------------------------------------------------------------
interface multi_channel_window_watchdog_if #(
    parameter int NUM_CHANNELS  = 4,
    parameter int COUNTER_WIDTH = 24
);
    localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    logic                     cfg_wr_en;
    logic [CH_W-1:0]          cfg_channel;
    logic [COUNTER_WIDTH-1:0] cfg_timeout;
    logic [COUNTER_WIDTH-1:0] cfg_window_open;
    logic                     cfg_enable;

    modport master (
        output cfg_wr_en,
        output cfg_channel,
        output cfg_timeout,
        output cfg_window_open,
        output cfg_enable
    );

    modport slave (
        input cfg_wr_en,
        input cfg_channel,
        input cfg_timeout,
        input cfg_window_open,
        input cfg_enable
    );
endinterface

// File: rtl/multi_channel_window_watchdog.sv
// ---------------------------------------------------------------------------
// multi_channel_window_watchdog
//
// N-channel watchdog. Every channel supervises one software task with its own
// timeout T and (optionally) an early-kick window W. Escalation is two-stage:
// the first expiry pulses irq_timeout and moves the channel to PRE_RESET; a
// second consecutive expiry without a kick triggers the shared wdt_reset
// pulse. A key-protected lock freezes all configuration writes.
//
// Optional feature macro: WDT_WINDOW_MODE_EN
//   defined   : a kick while count < W pulses early_kick_violation and acts
//               as a reset trigger.
//   undefined : W is ignored, every kick is accepted, early_kick_violation
//               stays 0 and cfg_window_open has no function.
//
// Ports:
//   clock                 system clock
//   reset_n               asynchronous active-low reset
//   cfg                   configuration bus (slave modport)
//   lock_req              set configuration lock (wins over unlock)
//   unlock_key            clears the lock when equal to UNLOCK_KEY
//   kick[N]               per-channel kick, rising-edge detected
//   force_reset_req       immediate reset request (ignores the lock)
//   irq_warning[N]        level, count has reached T - T/4
//   irq_timeout[N]        one-cycle pulse on first-stage expiry
//   early_kick_violation  one-cycle pulse on a kick before the window opens
//   wdt_reset             system reset pulse, RESET_PULSE_CYCLES long
//   channel_state[2N]     per-channel {IDLE=00, RUN=01, PRE_RESET=10}
//   timeout_event_count   saturating count of cycles with a reset trigger
//   config_locked         lock status
// ---------------------------------------------------------------------------
module multi_channel_window_watchdog #(
    parameter int                       NUM_CHANNELS       = 4,
    parameter int                       COUNTER_WIDTH      = 24,
    parameter logic [COUNTER_WIDTH-1:0] DEFAULT_TIMEOUT    = 24'hFF_FFFF,
    parameter int                       RESET_PULSE_CYCLES = 10,
    parameter logic [31:0]              UNLOCK_KEY         = 32'hDEAD_BEEF
) (
    input  logic                          clock,
    input  logic                          reset_n,
    multi_channel_window_watchdog_if.slave cfg,
    input  logic                          lock_req,
    input  logic [31:0]                   unlock_key,
    input  logic [NUM_CHANNELS-1:0]       kick,
    input  logic                          force_reset_req,
    output logic [NUM_CHANNELS-1:0]       irq_warning,
    output logic [NUM_CHANNELS-1:0]       irq_timeout,
    output logic [NUM_CHANNELS-1:0]       early_kick_violation,
    output logic                          wdt_reset,
    output logic [2*NUM_CHANNELS-1:0]     channel_state,
    output logic [15:0]                   timeout_event_count,
    output logic                          config_locked
);

    localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int CW   = COUNTER_WIDTH;
    localparam int PW   = $clog2(RESET_PULSE_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_PRE  = 2'b10
    } state_t;

    // -----------------------------------------------------------------------
    // Configuration write decode, shared by all channels
    // -----------------------------------------------------------------------
    logic          cfg_in_range;
    logic          wr_ok;
    logic [CW-1:0] new_timeout;

    assign cfg_in_range = (32'(cfg.cfg_channel) < 32'(NUM_CHANNELS));
    assign wr_ok        = cfg.cfg_wr_en && !config_locked && cfg_in_range;
    assign new_timeout  = (cfg.cfg_timeout == '0) ? DEFAULT_TIMEOUT : cfg.cfg_timeout;

`ifdef WDT_WINDOW_MODE_EN
    logic [CW-1:0] new_window;
    // A window that never closes before expiry would make every kick early,
    // so such a window is stored as "always open".
    assign new_window = (cfg.cfg_window_open >= new_timeout) ? '0 : cfg.cfg_window_open;
`else
    logic window_unused;
    assign window_unused = ^cfg.cfg_window_open;
`endif

    // -----------------------------------------------------------------------
    // Configuration lock: lock_req has priority over a matching key
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            config_locked <= 1'b0;
        end else if (lock_req) begin
            config_locked <= 1'b1;
        end else if (unlock_key == UNLOCK_KEY) begin
            config_locked <= 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Kick rising-edge detection
    // -----------------------------------------------------------------------
    logic [NUM_CHANNELS-1:0] kick_q;
    logic [NUM_CHANNELS-1:0] kick_edge;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            kick_q <= '0;
        end else begin
            kick_q <= kick;
        end
    end

    assign kick_edge = kick & ~kick_q;

    // -----------------------------------------------------------------------
    // Per-channel supervisor
    // Priority per edge: write > kick edge > expiry > increment.
    // -----------------------------------------------------------------------
    logic [NUM_CHANNELS-1:0] chan_trig;

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        state_t        state;
        logic [CW-1:0] count;
        logic [CW-1:0] timeout;
        logic          warn;
        logic          tmo_pulse;
        logic          early_pulse;

        logic          wr_hit;
        logic          active;
        logic          kick_early;
        logic          stage2;
        logic [CW-1:0] count_inc;
        logic [CW-1:0] warn_thr;

        assign wr_hit    = wr_ok && (cfg.cfg_channel == CH_W'(i));
        assign active    = (state != ST_IDLE);
        assign stage2    = (state == ST_PRE) && (count == timeout);
        assign count_inc = count + 1'b1;
        // Warning threshold is 75 % of T, computed without a multiplier.
        assign warn_thr  = timeout - (timeout >> 2);

`ifdef WDT_WINDOW_MODE_EN
        logic [CW-1:0] window;
        assign kick_early = active && kick_edge[i] && (count < window);
`else
        assign kick_early = 1'b0;
`endif

        // A kick edge pre-empts an expiry on the same edge, so stage-2 only
        // counts as a trigger when no kick edge arrives.
        assign chan_trig[i] = !wr_hit && active && (kick_edge[i] ? kick_early : stage2);

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                state       <= ST_IDLE;
                count       <= '0;
                timeout     <= DEFAULT_TIMEOUT;
                warn        <= 1'b0;
                tmo_pulse   <= 1'b0;
                early_pulse <= 1'b0;
`ifdef WDT_WINDOW_MODE_EN
                window      <= '0;
`endif
            end else begin
                tmo_pulse   <= 1'b0;
                early_pulse <= 1'b0;
                if (wr_hit) begin
                    timeout <= new_timeout;
`ifdef WDT_WINDOW_MODE_EN
                    window  <= new_window;
`endif
                    count   <= '0;
                    state   <= cfg.cfg_enable ? ST_RUN : ST_IDLE;
                    warn    <= 1'b0;
                end else if (!active) begin
                    count <= '0;
                    warn  <= 1'b0;
                end else if (kick_edge[i]) begin
                    // Early and on-time kicks both restart the period; an
                    // early one additionally reports the violation.
                    count       <= '0;
                    state       <= ST_RUN;
                    warn        <= 1'b0;
                    early_pulse <= kick_early;
                end else if (count == timeout) begin
                    count <= '0;
                    warn  <= 1'b0;
                    if (state == ST_RUN) begin
                        state     <= ST_PRE;
                        tmo_pulse <= 1'b1;
                    end else begin
                        state <= ST_RUN;
                    end
                end else begin
                    // Warning tracks the count value being loaded so that it
                    // is high exactly while count >= threshold.
                    count <= count_inc;
                    warn  <= (count_inc >= warn_thr);
                end
            end
        end

        assign irq_warning[i]          = warn;
        assign irq_timeout[i]          = tmo_pulse;
        assign early_kick_violation[i] = early_pulse;
        assign channel_state[2*i +: 2] = state;
    end

    // -----------------------------------------------------------------------
    // Reset pulse generator and event counter
    // -----------------------------------------------------------------------
    logic          any_trigger;
    logic [PW-1:0] pulse_cnt;

    assign any_trigger = (|chan_trig) || force_reset_req;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pulse_cnt           <= '0;
            wdt_reset           <= 1'b0;
            timeout_event_count <= '0;
        end else begin
            // A retrigger reloads the full length, so overlapping requests
            // stretch the pulse rather than being merged into the old one.
            if (any_trigger) begin
                pulse_cnt <= PW'(RESET_PULSE_CYCLES);
            end else if (pulse_cnt != '0) begin
                pulse_cnt <= pulse_cnt - 1'b1;
            end
            // Registered output equals "next pulse_cnt is non-zero".
            wdt_reset <= any_trigger || (pulse_cnt > PW'(1));

            if (any_trigger && (timeout_event_count != 16'hFFFF)) begin
                timeout_event_count <= timeout_event_count + 16'd1;
            end
        end
    end

endmodule
